ps2_rx_core: RTL and testbench

- PS/2 device-to-host receive engine; sits directly upstream of the APB4 PS/2 register wrapper.
- Synchronizes and filters the raw ps2_clk/ps2_dat pins and deserializes 11-bit frames: start, 8 data bits LSB first, odd parity, stop.
- Buffers good bytes in a first-word-fall-through FIFO and presents them on a valid/ready port.
- Provides sticky error flags and an interrupt level for the wrapper.

---
 rtl/ps2_rx_core.sv | 247 ++++++++++++++++++++++++
 tb/tb_ps2_rx_core.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_core.sv
// PS/2 device-to-host receive engine: pin conditioning, 11-bit frame
// deserializer, FWFT receive FIFO, sticky error flags and interrupt level.
module ps2_rx_core #(
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter int unsigned FILTER_LEN  = 4,
   parameter int unsigned TIMEOUT_CYC = 50000
) (
   input  logic                          clk_i,
   input  logic                          rst_n_i,
   input  logic                          en_i,
   input  logic                          ps2_clk_i,
   input  logic                          ps2_dat_i,
   output logic [7:0]                    dat_o,
   output logic                          dat_valid_o,
   input  logic                          dat_ready_i,
   output logic [$clog2(FIFO_DEPTH):0]   cnt_o,
   output logic                          par_err_o,
   output logic                          frm_err_o,
   output logic                          ovf_o,
   input  logic                          clr_err_i,
   output logic                          irq_o
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned FW = $clog2(FILTER_LEN + 1);
   localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } state_e;

   // Conditioning registers
   logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
   logic          filt_q, filt_d, filt_prev_q;
   logic [FW-1:0] run_q, run_d;
   logic          fall_c;

   // Frame engine registers
   state_e        state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          par_bit_q, par_bit_d;
   logic [TW-1:0] to_q, to_d;
   logic          timeout_c;
   logic          shift_c, par_lat_c, push_c, par_evt_c, frm_evt_c;

   // FIFO and status registers
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          valid_q, valid_d;
   logic          pop_c, full_c, wr_c, ovf_evt_c;
   logic          par_q, par_d, frm_q, frm_d, ovf_q, ovf_d;
   logic          irq_q, irq_d;

   // Glitch filter: follow the synchronized clock only after FILTER_LEN stable disagreeing samples
   always_comb begin
      filt_d = filt_q;
      run_d  = '0;
      if (clk_s2_q != filt_q) begin
         if (run_q == FW'(FILTER_LEN - 1)) begin
            filt_d = ~filt_q;
         end else begin
            run_d = run_q + FW'(1);
         end
      end
   end

   assign fall_c = filt_prev_q & ~filt_q;

   // Pin synchronizers and filtered clock; idle-high at reset
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         clk_s1_q    <= 1'b1;
         clk_s2_q    <= 1'b1;
         dat_s1_q    <= 1'b1;
         dat_s2_q    <= 1'b1;
         filt_q      <= 1'b1;
         filt_prev_q <= 1'b1;
         run_q       <= '0;
      end else begin
         clk_s1_q    <= ps2_clk_i;
         clk_s2_q    <= clk_s1_q;
         dat_s1_q    <= ps2_dat_i;
         dat_s2_q    <= dat_s1_q;
         filt_q      <= filt_d;
         filt_prev_q <= filt_q;
         run_q       <= run_d;
      end
   end

   assign timeout_c = (state_q != S_IDLE) && !fall_c && (to_q == TW'(TIMEOUT_CYC - 1));

   // FSM state register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: advance on filtered falling edges, abort on disable or timeout
   always_comb begin
      state_d = state_q;
      if (!en_i || timeout_c) begin
         state_d = S_IDLE;
      end else if (fall_c) begin
         case (state_q)
            S_IDLE:   if (!dat_s2_q) state_d = S_DATA;
            S_DATA:   if (bit_cnt_q == 3'd7) state_d = S_PARITY;
            S_PARITY: state_d = S_STOP;
            S_STOP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   // FSM outputs: shift/latch strobes and end-of-frame verdict (stop, then parity)
   always_comb begin
      shift_c   = 1'b0;
      par_lat_c = 1'b0;
      push_c    = 1'b0;
      par_evt_c = 1'b0;
      frm_evt_c = 1'b0;
      if (en_i) begin
         if (timeout_c) begin
            frm_evt_c = 1'b1;
         end else if (fall_c) begin
            case (state_q)
               S_DATA:   shift_c   = 1'b1;
               S_PARITY: par_lat_c = 1'b1;
               S_STOP: begin
                  if (!dat_s2_q) begin
                     frm_evt_c = 1'b1;
                  end else if ((^shreg_q ^ par_bit_q) == 1'b0) begin
                     par_evt_c = 1'b1;
                  end else begin
                     push_c = 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Deserializer datapath and inter-edge timeout counter
   always_comb begin
      bit_cnt_d = bit_cnt_q;
      shreg_d   = shreg_q;
      par_bit_d = par_bit_q;
      if (state_q == S_IDLE) begin
         bit_cnt_d = 3'd0;
      end
      if (shift_c) begin
         shreg_d   = {dat_s2_q, shreg_q[7:1]};
         bit_cnt_d = bit_cnt_q + 3'd1;
      end
      if (par_lat_c) begin
         par_bit_d = dat_s2_q;
      end
      if (!en_i || state_q == S_IDLE || fall_c || timeout_c) begin
         to_d = '0;
      end else begin
         to_d = to_q + TW'(1);
      end
   end

   // Deserializer registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         bit_cnt_q <= '0;
         shreg_q   <= '0;
         par_bit_q <= 1'b0;
         to_q      <= '0;
      end else begin
         bit_cnt_q <= bit_cnt_d;
         shreg_q   <= shreg_d;
         par_bit_q <= par_bit_d;
         to_q      <= to_d;
      end
   end

   // FIFO control, sticky flags and interrupt next-state
   always_comb begin
      pop_c     = valid_q & dat_ready_i;
      full_c    = (cnt_q == CW'(FIFO_DEPTH));
      wr_c      = push_c & (~full_c | pop_c);
      ovf_evt_c = push_c & full_c & ~pop_c;
      wr_ptr_d  = wr_c  ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d  = pop_c ? rd_ptr_q + AW'(1) : rd_ptr_q;
      cnt_d     = cnt_q;
      if (wr_c && !pop_c) begin
         cnt_d = cnt_q + CW'(1);
      end else if (!wr_c && pop_c) begin
         cnt_d = cnt_q - CW'(1);
      end
      valid_d = (cnt_d != '0);
      par_d   = par_evt_c | (par_q & ~clr_err_i);
      frm_d   = frm_evt_c | (frm_q & ~clr_err_i);
      ovf_d   = ovf_evt_c | (ovf_q & ~clr_err_i);
      irq_d   = en_i & (valid_d | par_d | frm_d | ovf_d);
   end

   // FIFO storage, pointers, occupancy and status registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         valid_q  <= 1'b0;
         par_q    <= 1'b0;
         frm_q    <= 1'b0;
         ovf_q    <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         if (wr_c) begin
            mem_q[wr_ptr_q] <= shreg_q;
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         valid_q  <= valid_d;
         par_q    <= par_d;
         frm_q    <= frm_d;
         ovf_q    <= ovf_d;
         irq_q    <= irq_d;
      end
   end

   assign dat_o       = mem_q[rd_ptr_q];
   assign dat_valid_o = valid_q;
   assign cnt_o       = cnt_q;
   assign par_err_o   = par_q;
   assign frm_err_o   = frm_q;
   assign ovf_o       = ovf_q;
   assign irq_o       = irq_q;

endmodule

// File: tb/tb_ps2_rx_core.sv
// Scoreboard bench for ps2_rx_core: frames are driven on the PS/2 pins, the
// expected byte/flag outcome is computed from the framing rules and queued,
// and a monitor compares each byte the DUT hands out.
module tb_ps2_rx_core;

   localparam int unsigned FD = 8;
   localparam int unsigned FL = 4;
   localparam int unsigned TO = 400;
   localparam int H = 20;

   logic       clk_i = 1'b0;
   logic       rst_n_i = 1'b0;
   logic       en_i = 1'b0;
   logic       ps2_clk_i = 1'b1;
   logic       ps2_dat_i = 1'b1;
   logic [7:0] dat_o;
   logic       dat_valid_o;
   logic       dat_ready_i = 1'b0;
   logic [3:0] cnt_o;
   logic       par_err_o, frm_err_o, ovf_o;
   logic       clr_err_i = 1'b0;
   logic       irq_o;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] exp_q[$];
   logic       par_exp = 1'b0, frm_exp = 1'b0, ovf_exp = 1'b0;
   logic       rnd_mode = 1'b0;

   ps2_rx_core #(.FIFO_DEPTH(FD), .FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i),
      .ps2_clk_i(ps2_clk_i), .ps2_dat_i(ps2_dat_i),
      .dat_o(dat_o), .dat_valid_o(dat_valid_o), .dat_ready_i(dat_ready_i),
      .cnt_o(cnt_o), .par_err_o(par_err_o), .frm_err_o(frm_err_o),
      .ovf_o(ovf_o), .clr_err_i(clr_err_i), .irq_o(irq_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic cyc(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Compare occupancy, flags and interrupt against the model at a quiet point
   task automatic chk_state(input string tag);
      chk({tag, ".cnt"}, int'(cnt_o), exp_q.size());
      chk({tag, ".valid"}, int'(dat_valid_o), int'(exp_q.size() != 0));
      chk({tag, ".par"}, int'(par_err_o), int'(par_exp));
      chk({tag, ".frm"}, int'(frm_err_o), int'(frm_exp));
      chk({tag, ".ovf"}, int'(ovf_o), int'(ovf_exp));
      chk({tag, ".irq"}, int'(irq_o),
          int'(en_i & ((exp_q.size() != 0) | par_exp | frm_exp | ovf_exp)));
   endtask

   // Drive nbits of an LSB-first frame, each bit held across a full PS/2 clock
   task automatic send_raw(input logic [10:0] f, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         ps2_dat_i = f[i];
         cyc(H / 2);
         ps2_clk_i = 1'b0;
         cyc(H);
         ps2_clk_i = 1'b1;
         cyc(H / 2);
      end
      ps2_dat_i = 1'b1;
      cyc(4);
   endtask

   // Issue a full frame; the expected outcome is queued before the bits go out
   task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
      logic [10:0] f;
      logic        p;
      p = ~(^d) ^ bad_par;
      f = {~bad_stop, p, d, 1'b0};
      if (bad_stop) frm_exp = 1'b1;
      else if (bad_par) par_exp = 1'b1;
      else if (exp_q.size() < FD) exp_q.push_back(d);
      else ovf_exp = 1'b1;
      send_raw(f, 11);
   endtask

   task automatic clear_flags();
      clr_err_i = 1'b1;
      cyc(1);
      clr_err_i = 1'b0;
      par_exp = 1'b0;
      frm_exp = 1'b0;
      ovf_exp = 1'b0;
      cyc(1);
   endtask

   // Pop one entry at a time and watch the occupancy step down
   task automatic drain_steps(input string tag);
      int n;
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         dat_ready_i = 1'b1;
         cyc(1);
         dat_ready_i = 1'b0;
         chk({tag, ".cnt_step"}, int'(cnt_o), exp_q.size());
      end
      chk({tag, ".valid_end"}, int'(dat_valid_o), 0);
   endtask

   // Pop everything with a bounded wait
   task automatic drain(input string tag);
      int budget;
      budget = 4 * FD + 10;
      dat_ready_i = 1'b1;
      while (dat_valid_o && budget > 0) begin
         cyc(1);
         budget--;
      end
      dat_ready_i = 1'b0;
      chk({tag, ".drain_done"}, int'(budget > 0), 1);
      chk({tag, ".exp_left"}, exp_q.size(), 0);
   endtask

   initial begin
      fork
         // Monitor: every accepted pop must match the oldest expected byte
         forever begin
            @(negedge clk_i);
            if (rst_n_i && dat_valid_o && dat_ready_i) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL pop_unexpected: got %02h expected nothing", dat_o);
               end else begin
                  chk("pop_byte", int'(dat_o), int'(exp_q.pop_front()));
               end
            end
         end
         // Random consumer back-pressure
         forever begin
            @(posedge clk_i);
            #1;
            if (rnd_mode) dat_ready_i = 1'($urandom_range(0, 1));
         end
      join_none

      // Reset values
      cyc(3);
      chk("rst.dat", int'(dat_o), 0);
      chk("rst.valid", int'(dat_valid_o), 0);
      chk("rst.cnt", int'(cnt_o), 0);
      chk("rst.irq", int'(irq_o), 0);
      rst_n_i = 1'b1;
      en_i = 1'b1;
      cyc(5);
      chk_state("idle");

      // Single frame 0x1C held in the FIFO
      send_frame(8'h1C, 1'b0, 1'b0);
      cyc(4);
      chk("t1.dat", int'(dat_o), 8'h1C);
      chk_state("t1");
      en_i = 1'b0;
      cyc(2);
      chk_state("t1.dis");
      en_i = 1'b1;
      cyc(2);
      drain("t1");

      // Back-to-back frames, then ordered drain
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b0);
      send_frame(8'hAA, 1'b0, 1'b0);
      cyc(4);
      chk_state("t2");
      drain_steps("t2");

      // Parity error then clear
      send_frame(8'h1C, 1'b1, 1'b0);
      cyc(4);
      chk_state("t3");
      clear_flags();
      chk_state("t3.clr");

      // Stop-bit error
      send_frame(8'h55, 1'b0, 1'b1);
      cyc(4);
      chk_state("t4.stop");
      clear_flags();

      // Timeout: start plus three data bits then clock parked high
      send_raw({1'b1, 1'b1, 8'h29, 1'b0}, 4);
      cyc(TO + 20);
      frm_exp = 1'b1;
      chk_state("t4.to");
      clear_flags();
      send_frame(8'h29, 1'b0, 1'b0);
      cyc(4);
      chk_state("t4.after");
      drain("t4");

      // Overflow with nine frames into eight entries
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0);
      cyc(4);
      chk_state("t5");
      drain("t5");
      clear_flags();

      // One-cycle clock glitch with data low must not start a frame
      ps2_dat_i = 1'b0;
      cyc(2);
      ps2_clk_i = 1'b0;
      cyc(1);
      ps2_clk_i = 1'b1;
      cyc(10);
      ps2_dat_i = 1'b1;
      cyc(5);
      send_frame(8'h1C, 1'b0, 1'b0);
      cyc(4);
      chk_state("t6.glitch");

      // Reset mid-frame with a byte already buffered
      send_raw({1'b1, 1'b0, 8'h1C, 1'b0}, 5);
      rst_n_i = 1'b0;
      #1;
      exp_q.delete();
      chk("t6.rst.dat", int'(dat_o), 0);
      chk_state("t6.rst");
      cyc(2);
      rst_n_i = 1'b1;
      cyc(3);
      send_frame(8'h1C, 1'b0, 1'b0);
      cyc(4);
      chk_state("t6.after");
      drain("t6");

      // Randomized frames under random back-pressure
      rnd_mode = 1'b1;
      for (int i = 0; i < 24; i++) begin
         int k;
         k = $urandom_range(0, 5);
         send_frame(8'($urandom), 1'(k == 0), 1'(k == 1));
      end
      rnd_mode = 1'b0;
      #1;
      dat_ready_i = 1'b0;
      cyc(2);
      drain("rnd");
      chk_state("rnd");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
